note_bin_search: RTL and testbench

- Parametrised successor to the linear bin-to-note lookup.
- Maps a spectral peak bin index to a note index by binary search over a run-time programmable table of ascending per-note upper bin bounds.
- Deterministic latency, ready/valid handshakes on both sides, explicit below/above-range flags.
- Sits between the FFT peak detector and the note display/transcription logic.

---
 rtl/note_pkg.sv | 24 ++
 rtl/note_bin_table.sv | 50 +++++
 rtl/note_bin_search.sv | 267 ++++++++++++++++++++++++++
 tb/tb_note_bin_search.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared types and constants for the bin-to-note binary search block.
package note_pkg;

  localparam int DEFAULT_NUM = 22;

  // Per-note upper bin bounds loaded into the table at power-up.
  localparam int DEFAULT_BIN_FLOOR [DEFAULT_NUM] = '{
    32'd63,  32'd66,  32'd70,  32'd74,  32'd79,  32'd84,  32'd89,  32'd94,
    32'd100, 32'd106, 32'd112, 32'd119, 32'd126, 32'd133, 32'd141, 32'd149,
    32'd158, 32'd168, 32'd178, 32'd188, 32'd200, 32'd212
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HYST   = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic int search_steps(input int num_notes);
    return $clog2(num_notes + 1);
  endfunction

endpackage

// File: rtl/note_bin_table.sv
// Programmable table of ascending per-note upper bin bounds.
// One write port, one combinational read port; contents survive reset.
module note_bin_table
  import note_pkg::*;
#(
  parameter int NUM_NOTES = 22,
  parameter int TBL_W     = 10,
  parameter int ADDR_W    = $clog2(NUM_NOTES)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [TBL_W-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [TBL_W-1:0]  rd_data_o
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_NOTES);

  function automatic logic [NUM_NOTES-1:0][TBL_W-1:0] init_table();
    logic [NUM_NOTES-1:0][TBL_W-1:0] t;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (i < DEFAULT_NUM) begin
        t[i] = TBL_W'(DEFAULT_BIN_FLOOR[i]);
      end else begin
        t[i] = '1;
      end
    end
    return t;
  endfunction

  logic [NUM_NOTES-1:0][TBL_W-1:0] mem_q = init_table();

  // Table write; out-of-range addresses are ignored.
  always_ff @(posedge clk_i) begin
    if (we_i && ({1'b0, wr_addr_i} < LIMIT)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port; out-of-range addresses return all-ones.
  always_comb begin
    if ({1'b0, rd_addr_i} < LIMIT) begin
      rd_data_o = mem_q[rd_addr_i];
    end else begin
      rd_data_o = '1;
    end
  end

endmodule

// File: rtl/note_bin_search.sv
// Peak bin -> note index by fixed-latency binary search over note_bin_table.
// Optional hysteresis stage enabled by defining NOTE_BIN_SEARCH_HYST_EN.
module note_bin_search
  import note_pkg::*;
#(
  parameter int NUM_NOTES = 22,
  parameter int BIN_W     = 13,
  parameter int TBL_W     = 10,
  parameter int NOTE_W    = 6,
  parameter int NOTE_BASE = 32,
  parameter int HYST_BINS = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [BIN_W-1:0]             bin_index,
  input  logic                         bin_valid_in,
  output logic                         bin_ready_out,
  output logic [NOTE_W-1:0]            note_index,
  output logic                         below_range,
  output logic                         above_range,
  output logic                         note_valid_out,
  input  logic                         note_ready_in,
  input  logic                         tbl_we_in,
  input  logic [$clog2(NUM_NOTES)-1:0] tbl_addr_in,
  input  logic [TBL_W-1:0]             tbl_data_in,
  output logic                         busy_out
);

  localparam int IDX_W = $clog2(NUM_NOTES);
  localparam int POS_W = $clog2(NUM_NOTES + 1);
  localparam int STEPS = search_steps(NUM_NOTES);
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam int CMP_W = (BIN_W > TBL_W) ? BIN_W : TBL_W;
  localparam logic [POS_W-1:0] POS_MAX   = POS_W'(NUM_NOTES);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_e              state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [POS_W-1:0]    lo_q, lo_d, hi_q, hi_d;
  logic [CNT_W-1:0]    step_q, step_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                below_q, below_d, above_q, above_d;
  logic                valid_q, valid_d, ready_q, ready_d, busy_q, busy_d;

  logic [POS_W:0]      sum_s;
  logic [POS_W-1:0]    mid_s, lo_n_s, hi_n_s, load_pos_s;
  logic                narrow_s, ge_s, tbl_we_s, load_s;
  logic [IDX_W-1:0]    rd_addr_s;
  logic [TBL_W-1:0]    rd_data_s;

`ifdef NOTE_BIN_SEARCH_HYST_EN
  logic [POS_W-1:0]    r_q, r_d, prev_q, prev_d, min_pos_s;
  logic                prev_vld_q, prev_vld_d;
  logic                r_in_s, p_in_s, adj_s, near_s, hold_s;
  logic [CMP_W-1:0]    bin_x_s, bnd_x_s, dist_s;
`endif

  note_bin_table #(
    .NUM_NOTES (NUM_NOTES),
    .TBL_W     (TBL_W)
  ) u_table (
    .clk_i     (clk_in),
    .we_i      (tbl_we_s),
    .wr_addr_i (tbl_addr_in),
    .wr_data_i (tbl_data_in),
    .rd_addr_i (rd_addr_s),
    .rd_data_o (rd_data_s)
  );

  assign sum_s    = {1'b0, lo_q} + {1'b0, hi_q};
  assign mid_s    = sum_s[POS_W:1];
  assign narrow_s = (lo_q < hi_q);
  assign ge_s     = (CMP_W'(rd_data_s) >= CMP_W'(bin_q));

  // One bisection step; the interval is held once it has collapsed.
  always_comb begin
    lo_n_s = lo_q;
    hi_n_s = hi_q;
    if (narrow_s) begin
      if (ge_s) begin
        hi_n_s = mid_s;
      end else begin
        lo_n_s = mid_s + 1'b1;
      end
    end else begin
      lo_n_s = lo_q;
      hi_n_s = hi_q;
    end
  end

`ifdef NOTE_BIN_SEARCH_HYST_EN
  assign min_pos_s = (r_q < prev_q) ? r_q : prev_q;
  assign r_in_s    = (r_q != '0) && (r_q != POS_MAX);
  assign p_in_s    = prev_vld_q && (prev_q != '0) && (prev_q != POS_MAX);
  assign adj_s     = ({1'b0, r_q} == ({1'b0, prev_q} + (POS_W + 1)'(1))) ||
                     ({1'b0, prev_q} == ({1'b0, r_q} + (POS_W + 1)'(1)));
  assign bin_x_s   = CMP_W'(bin_q);
  assign bnd_x_s   = CMP_W'(rd_data_s);
  assign dist_s    = (bin_x_s >= bnd_x_s) ? (bin_x_s - bnd_x_s) : (bnd_x_s - bin_x_s);
  assign near_s    = (dist_s <= CMP_W'(HYST_BINS));
  assign hold_s    = r_in_s && p_in_s && adj_s && near_s;
`endif

  // Read address: bisection midpoint, or the shared boundary during HYST.
  always_comb begin
    rd_addr_s = IDX_W'(mid_s);
`ifdef NOTE_BIN_SEARCH_HYST_EN
    if (state_q == HYST) begin
      rd_addr_s = IDX_W'(min_pos_s);
    end else begin
      rd_addr_s = IDX_W'(mid_s);
    end
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    step_d     = step_q;
    tbl_we_s   = 1'b0;
    load_s     = 1'b0;
    load_pos_s = lo_n_s;
`ifdef NOTE_BIN_SEARCH_HYST_EN
    r_d        = r_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
`endif
    case (state_q)
      IDLE: begin
        tbl_we_s = tbl_we_in;
        if (bin_valid_in) begin
          bin_d   = bin_index;
          lo_d    = '0;
          hi_d    = POS_MAX;
          step_d  = '0;
          state_d = SEARCH;
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        lo_d   = lo_n_s;
        hi_d   = hi_n_s;
        step_d = step_q + 1'b1;
        if (step_q == LAST_STEP) begin
`ifdef NOTE_BIN_SEARCH_HYST_EN
          r_d     = lo_n_s;
          state_d = HYST;
`else
          load_s     = 1'b1;
          load_pos_s = lo_n_s;
          state_d    = DONE;
`endif
        end else begin
          state_d = SEARCH;
        end
      end
`ifdef NOTE_BIN_SEARCH_HYST_EN
      HYST: begin
        load_s  = 1'b1;
        state_d = DONE;
        if (hold_s) begin
          load_pos_s = prev_q;
        end else begin
          load_pos_s = r_q;
          if (r_in_s) begin
            prev_d     = r_q;
            prev_vld_d = 1'b1;
          end else begin
            prev_d     = prev_q;
            prev_vld_d = prev_vld_q;
          end
        end
      end
`endif
      DONE: begin
        if (note_ready_in) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Position -> note index and range flags; held until the next result.
  always_comb begin
    note_d  = note_q;
    below_d = below_q;
    above_d = above_q;
    if (load_s) begin
      if (load_pos_s == '0) begin
        note_d  = '0;
        below_d = 1'b1;
        above_d = 1'b0;
      end else if (load_pos_s >= POS_MAX) begin
        note_d  = '0;
        below_d = 1'b0;
        above_d = 1'b1;
      end else begin
        note_d  = NOTE_W'(NOTE_BASE) + NOTE_W'(load_pos_s);
        below_d = 1'b0;
        above_d = 1'b0;
      end
    end else begin
      note_d  = note_q;
      below_d = below_q;
      above_d = above_q;
    end
    valid_d = (state_d == DONE);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      step_q     <= '0;
      note_q     <= '0;
      below_q    <= 1'b0;
      above_q    <= 1'b0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
`ifdef NOTE_BIN_SEARCH_HYST_EN
      r_q        <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      step_q     <= step_d;
      note_q     <= note_d;
      below_q    <= below_d;
      above_q    <= above_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
`ifdef NOTE_BIN_SEARCH_HYST_EN
      r_q        <= r_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
`endif
    end
  end

  assign bin_ready_out  = ready_q;
  assign note_index     = note_q;
  assign below_range    = below_q;
  assign above_range    = above_q;
  assign note_valid_out = valid_q;
  assign busy_out       = busy_q;

endmodule

// File: tb/tb_note_bin_search.sv
// Directed bench for note_bin_search (default build): a table-counting
// reference model plus a per-cycle output compare process.
module tb_note_bin_search;

  localparam int NN = 22;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [12:0] bin_index = 13'd0;
  logic        bin_valid_in = 1'b0;
  logic        bin_ready_out;
  logic [5:0]  note_index;
  logic        below_range, above_range, note_valid_out;
  logic        note_ready_in = 1'b0;
  logic        tbl_we_in = 1'b0;
  logic [4:0]  tbl_addr_in = 5'd0;
  logic [9:0]  tbl_data_in = 10'd0;
  logic        busy_out;

  int n_cmp = 0;
  int n_bad = 0;
  int mdl_tbl [NN] = '{63, 66, 70, 74, 79, 84, 89, 94, 100, 106, 112, 119,
                       126, 133, 141, 149, 158, 168, 178, 188, 200, 212};
  int exp_note = 0;
  int exp_below = 0;
  int exp_above = 0;

  always #5 clk_in = ~clk_in;

  note_bin_search dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .bin_index      (bin_index),
    .bin_valid_in   (bin_valid_in),
    .bin_ready_out  (bin_ready_out),
    .note_index     (note_index),
    .below_range    (below_range),
    .above_range    (above_range),
    .note_valid_out (note_valid_out),
    .note_ready_in  (note_ready_in),
    .tbl_we_in      (tbl_we_in),
    .tbl_addr_in    (tbl_addr_in),
    .tbl_data_in    (tbl_data_in),
    .busy_out       (busy_out)
  );

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Position = number of table entries strictly below the bin.
  function automatic int model_pos(input int b);
    int r = 0;
    for (int i = 0; i < NN; i++) begin
      if (mdl_tbl[i] < b) r++;
    end
    return r;
  endfunction

  task automatic model_out(input int b, output int n, output int bl, output int ab);
    int r;
    r  = model_pos(b);
    bl = (r == 0) ? 1 : 0;
    ab = (r == NN) ? 1 : 0;
    n  = (bl == 1 || ab == 1) ? 0 : ((32 + r) % 64);
  endtask

  // Whenever a result is presented it must match the model and block new queries.
  always @(negedge clk_in) begin
    if (!rst_in && note_valid_out) begin
      chk("note_index", int'(note_index), exp_note);
      chk("below_range", int'(below_range), exp_below);
      chk("above_range", int'(above_range), exp_above);
      chk("ready_in_done", int'(bin_ready_out), 0);
    end
  end

  task automatic tbl_write(input int a, input int d);
    @(negedge clk_in);
    tbl_we_in   = 1'b1;
    tbl_addr_in = 5'(a);
    tbl_data_in = 10'(d);
    @(negedge clk_in);
    tbl_we_in = 1'b0;
    if (a < NN) mdl_tbl[a] = d;
  endtask

  // mode 0: plain; 1: attempt a table write mid-search; 2: reset mid-search.
  task automatic query(input int b, input int h_note, input int h_bl, input int h_ab,
                       input int hold, input int mode);
    int lat;
    int n, bl, ab;
    model_out(b, n, bl, ab);
    chk($sformatf("model_note_%0d", b), n, h_note);
    chk($sformatf("model_below_%0d", b), bl, h_bl);
    chk($sformatf("model_above_%0d", b), ab, h_ab);
    exp_note  = n;
    exp_below = bl;
    exp_above = ab;
    @(negedge clk_in);
    bin_index    = 13'(b);
    bin_valid_in = 1'b1;
    @(negedge clk_in);
    bin_valid_in = 1'b0;
    chk("busy_after_accept", int'(busy_out), 1);
    chk("ready_after_accept", int'(bin_ready_out), 0);
    lat = 0;
    while (!note_valid_out && lat < 20) begin
      if (mode == 1 && lat == 2) begin
        tbl_we_in   = 1'b1;
        tbl_addr_in = 5'd4;
        tbl_data_in = 10'd83;
      end
      if (mode == 2 && lat == 2) rst_in = 1'b1;
      @(negedge clk_in);
      lat++;
      tbl_we_in = 1'b0;
      if (mode == 2 && rst_in) begin
        chk("rst_note_index", int'(note_index), 0);
        chk("rst_below", int'(below_range), 0);
        chk("rst_above", int'(above_range), 0);
        chk("rst_valid", int'(note_valid_out), 0);
        chk("rst_busy", int'(busy_out), 0);
        chk("rst_ready", int'(bin_ready_out), 1);
        rst_in = 1'b0;
        return;
      end
    end
    chk($sformatf("latency_%0d", b), lat, 5);
    repeat (hold) @(negedge clk_in);
    note_ready_in = 1'b1;
    @(negedge clk_in);
    note_ready_in = 1'b0;
    chk("valid_after_release", int'(note_valid_out), 0);
    chk("ready_after_release", int'(bin_ready_out), 1);
    chk("busy_after_release", int'(busy_out), 0);
    chk("held_note_after_release", int'(note_index), exp_note);
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    chk("reset_note_index", int'(note_index), 0);
    chk("reset_below", int'(below_range), 0);
    chk("reset_above", int'(above_range), 0);
    chk("reset_valid", int'(note_valid_out), 0);
    chk("reset_busy", int'(busy_out), 0);
    chk("reset_ready", int'(bin_ready_out), 1);
    rst_in = 1'b0;

    query(63,   0,  1, 0, 0,  0);
    query(64,   33, 0, 0, 0,  0);
    query(200,  52, 0, 0, 0,  0);
    query(212,  53, 0, 0, 0,  0);
    query(213,  0,  0, 1, 10, 0);
    query(5000, 0,  0, 1, 0,  0);

    tbl_write(1, 65);
    query(66, 34, 0, 0, 0, 0);

    query(80, 37, 0, 0, 0, 1);
    query(80, 37, 0, 0, 0, 0);

    query(64,  33, 0, 0, 0, 0);
    query(100, 40, 0, 0, 0, 2);
    query(141, 46, 0, 0, 3, 0);

    tbl_write(25, 5);
    query(66, 34, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
